// File: rtl/mod_divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : mod_divisor_secuencial
// Purpose  : Sequential unsigned restoring divider for the ALU datapath.
//            Produces one quotient bit per clock behind a START/DONE
//            handshake. A zero divisor bypasses the iteration and raises DZ.
// Revision : 1.0 - initial release
// ============================================================================
module mod_divisor_secuencial #(
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   ash_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   div_q;     // captured divisor
  logic [WIDTH-1:0]   p_q;       // partial remainder (always < divisor)
  logic [CNT_W-1:0]   cnt_q;     // quotient bits still to produce
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH:0]     trial_d;   // {P, next dividend bit}, one bit wider than P
  logic               ge_d;      // trial fits the divisor -> quotient bit 1
  logic [WIDTH-1:0]   sub_d;
  logic [WIDTH-1:0]   p_d;
  logic [WIDTH-1:0]   ash_d;

  // One restoring step: shift in next dividend bit, subtract when it fits.
  always_comb begin
    trial_d = {p_q, ash_q[WIDTH-1]};
    ge_d    = (trial_d >= {1'b0, div_q});
    // The difference is below the divisor, so the low WIDTH bits suffice.
    sub_d   = trial_d[WIDTH-1:0] - div_q;
    p_d     = ge_d ? sub_d : trial_d[WIDTH-1:0];
    ash_d   = {ash_q[WIDTH-2:0], ge_d};
  end

  // Control FSM plus datapath; results and DONE are registered on FIN entry.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ash_q   <= '0;
      div_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            ash_q  <= A;
            busy_q <= 1'b1;
            if (B != '0) begin
              div_q   <= B;
              p_q     <= '0;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= S_CALC;
            end else begin
              // Divide-by-zero: publish saturated quotient and raw dividend.
              q_q     <= '1;
              r_q     <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_CALC: begin
          p_q   <= p_d;
          ash_q <= ash_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            q_q     <= ash_d;
            r_q     <= p_d;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_divisor_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_divisor_secuencial
// Purpose  : Self-checking bench for mod_divisor_secuencial. A cycle-level
//            behavioural model (plain / and %) is compared against every
//            output on every cycle; directed cases pin literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_divisor_secuencial;

  localparam int WIDTH = 6;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DZ;
  logic             BUSY;
  logic             DONE;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mod_divisor_secuencial #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .DZ   (DZ),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: an accepted op yields A/B, A%B after WIDTH more
  // edges; a zero divisor completes on the accepting edge itself.
  logic [WIDTH-1:0] m_q, m_r, m_pq, m_pr;
  logic             m_dz, m_busy, m_done, m_acc;
  int               m_pend;

  initial begin
    m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_pend = 0; m_pq = '0; m_pr = '0; m_acc = 1'b0;
  end

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_pend = 0;
    end else begin
      m_acc  = START && !m_busy;
      m_done = 1'b0;
      if (m_pend > 0) begin
        m_pend = m_pend - 1;
        if (m_pend == 0) begin
          m_q = m_pq; m_r = m_pr; m_dz = 1'b0; m_done = 1'b1;
        end
      end
      if (m_acc) begin
        if (B == '0) begin
          m_q = '1; m_r = A; m_dz = 1'b1; m_done = 1'b1;
        end else begin
          m_pq   = A / B;
          m_pr   = A % B;
          m_pend = WIDTH;
        end
      end
      m_busy = (m_pend > 0) || m_done;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      n_vec++;
      if (Q !== m_q || R !== m_r || DZ !== m_dz || BUSY !== m_busy || DONE !== m_done) begin
        n_err++;
        $display("FAIL cycle_model t=%0t: got Q=%0d R=%0d DZ=%b BUSY=%b DONE=%b, want Q=%0d R=%0d DZ=%b BUSY=%b DONE=%b",
                 $time, Q, R, DZ, BUSY, DONE, m_q, m_r, m_dz, m_busy, m_done);
      end
    end
  end

  task automatic expect_eq(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Apply one START pulse; returns at the negedge after the accepting edge.
  task automatic start_op(input int a, input int b);
    A     = WIDTH'(a);
    B     = WIDTH'(b);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Bounded wait for DONE; lat counts negedges since the accepting edge.
  task automatic wait_done(input int maxc, input int lat0, output bit got, output int lat);
    got = 1'b0;
    lat = lat0;
    while (!got && lat <= maxc) begin
      if (DONE === 1'b1) got = 1'b1;
      else begin
        @(negedge CLK);
        lat++;
      end
    end
  endtask

  task automatic op_literal(input string nm, input int a, input int b,
                            input int eq, input int er, input int edz, input int elat);
    bit got;
    int lat;
    start_op(a, b);
    wait_done(12, 1, got, lat);
    expect_eq({nm, "_done_seen"}, int'(got), 1);
    if (got) begin
      expect_eq({nm, "_latency"}, lat, elat);
      expect_eq({nm, "_Q"}, int'(Q), eq);
      expect_eq({nm, "_R"}, int'(R), er);
      expect_eq({nm, "_DZ"}, int'(DZ), edz);
      @(negedge CLK);
      expect_eq({nm, "_done_single"}, int'(DONE), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit got;
    int lat;
    int nd;
    int bnd_a [4] = '{63, 5, 63, 0};
    int bnd_b [4] = '{1, 7, 63, 9};
    int bnd_q [4] = '{63, 0, 1, 0};
    int bnd_r [4] = '{0, 5, 0, 0};

    RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    expect_eq("reset_Q", int'(Q), 0);
    expect_eq("reset_R", int'(R), 0);
    expect_eq("reset_flags", int'({DZ, BUSY, DONE}), 0);
    RST_N = 1'b1;

    op_literal("basic_45_6", 45, 6, 7, 3, 0, 7);

    for (int i = 0; i < 4; i++)
      op_literal("boundary", bnd_a[i], bnd_b[i], bnd_q[i], bnd_r[i], 0, 7);

    op_literal("divzero_17", 17, 0, 63, 17, 1, 1);
    op_literal("after_dz_12_4", 12, 4, 3, 0, 0, 7);

    // START during CALC must be ignored, not queued.
    start_op(40, 3);
    repeat (2) @(negedge CLK);
    A = 6'd1; B = 6'd1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(12, 4, got, lat);
    expect_eq("busy_rej_done_seen", int'(got), 1);
    expect_eq("busy_rej_Q", int'(Q), 13);
    expect_eq("busy_rej_R", int'(R), 1);
    nd = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE) nd++;
    end
    expect_eq("busy_rej_no_second_done", nd, 0);

    // Reset in the middle of CALC aborts without DONE.
    start_op(50, 7);
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    expect_eq("midrst_Q", int'(Q), 0);
    expect_eq("midrst_R", int'(R), 0);
    expect_eq("midrst_flags", int'({DZ, BUSY, DONE}), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    op_literal("after_rst_50_7", 50, 7, 7, 1, 0, 7);

    // Exhaustive sweep with START held high (back-to-back operations).
    START = 1'b1;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        A = WIDTH'(a);
        B = WIDTH'(b);
        @(negedge CLK);
        wait_done(14, 1, got, lat);
        if (!got) expect_eq("exh_done_seen", 0, 1);
        else if (b != 0) begin
          if (int'(Q) * b + int'(R) != a || int'(R) >= b)
            expect_eq($sformatf("exh_inv_a%0d_b%0d_Q*B+R", a, b), int'(Q) * b + int'(R), a);
          else n_vec++;
        end else begin
          if (Q != 6'd63 || int'(R) != a || DZ != 1'b1)
            expect_eq($sformatf("exh_dz_a%0d_R", a), int'(R), a);
          else n_vec++;
        end
      end
    end
    START = 1'b0;
    repeat (10) @(negedge CLK);

    // Randomized traffic, including stray STARTs and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      RST_N = ($urandom_range(0, 99) != 0);
      START = 1'($urandom_range(0, 1));
      A     = WIDTH'($urandom);
      B     = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      @(negedge CLK);
    end
    RST_N = 1'b1;
    START = 1'b0;
    repeat (12) @(negedge CLK);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
